parity_frame_rx: RTL and testbench

Serial frame receiver that sits directly upstream of the parity generator/checker. It deserializes an asynchronous-style frame (start bit, DATA_W data bits LSB-first, one parity bit, one stop bit) from a single serial line. It presents the recovered data word and received parity bit, and pulses a completion strobe. It also computes its own parity verdict, so the downstream checker output can be cross-checked in the bench.

---
 rtl/parity_frame_rx_if.sv | 34 +++
 rtl/parity_frame_rx.sv | 188 ++++++++++++++++++
 tb/tb_parity_frame_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_rx_if.sv
// Serial-in / word-out bundle for the parity frame receiver.
// master drives the serial line and observes results; slave is the receiver.
// All result signals are registered inside the receiver.
interface parity_frame_rx_if #(
    parameter int DATA_W = 4
) ();
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              parity_out;
    logic              frame_done;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output rx,
        input  data_out,
        input  parity_out,
        input  frame_done,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output parity_out,
        output frame_done,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop; reports word, parity and errors.
// Latency: results and frame_done are registered one cycle after the mid-bit stop sample.
// No backpressure: frame_done is a one-cycle strobe and results hold until the next frame completes.
module parity_frame_rx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD          = 0
) (
    input  logic              clk,
    input  logic              rst,
    parity_frame_rx_if.slave  bus
);

    // Counter spans one bit period; bit index spans the data word.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic          ODD_BIT  = (ODD != 0);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic              rx_meta;
    logic              rx_s;
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_s;

    logic              start_pt;
    logic              bit_pt;
    logic              data_pt;
    logic              parity_pt;
    logic              stop_pt;
    logic              last_data;

    logic [DATA_W-1:0] data_out_r;
    logic              parity_out_r;
    logic              frame_done_r;
    logic              parity_err_r;
    logic              frame_err_r;

    // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Sample-point strobes: mid start bit for the false-start check, then one full bit period apart.
    always_comb begin
        start_pt  = (state == S_START) && (cnt == HALF_M1);
        bit_pt    = (cnt == FULL_M1);
        data_pt   = (state == S_DATA)   && bit_pt;
        parity_pt = (state == S_PARITY) && bit_pt;
        stop_pt   = (state == S_STOP)   && bit_pt;
        last_data = (bit_idx == LAST_BIT);
    end

    // Next-state decode; the stop bit level decides whether the line must recover before re-arming.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (start_pt) begin
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (data_pt && last_data) begin
                    state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (parity_pt) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (stop_pt) begin
                    state_nxt = rx_s ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit-period counter: held at zero while waiting for a line edge, restarted at every sample point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == S_IDLE) || (state == S_WAIT_HIGH)) begin
            cnt <= '0;
        end else if (start_pt || bit_pt) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data bit index: cleared when the start bit is confirmed, advanced on each data sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
        end else if (start_pt) begin
            bit_idx <= '0;
        end else if (data_pt && !last_data) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Capture data bits LSB-first and the parity bit, only at their sample points.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            par_s <= 1'b0;
        end else begin
            if (data_pt) begin
                shreg[bit_idx] <= rx_s;
            end
            if (parity_pt) begin
                par_s <= rx_s;
            end
        end
    end

    // Publish the frame at the stop sample; results hold until the next completed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r   <= '0;
            parity_out_r <= 1'b0;
            frame_done_r <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_done_r <= stop_pt;
            if (stop_pt) begin
                data_out_r   <= shreg;
                parity_out_r <= par_s;
                parity_err_r <= (par_s != ((^shreg) ^ ODD_BIT));
                frame_err_r  <= ~rx_s;
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.parity_out = parity_out_r;
    assign bus.frame_done = frame_done_r;
    assign bus.parity_err = parity_err_r;
    assign bus.frame_err  = frame_err_r;
    // busy follows the state register, so it drops on the same edge frame_done rises.
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: even-parity instance dut0, odd-parity instance dut1.
// Expected values are hand-computed from the frame format and the sample-point timing.
// Results are sampled on the falling clock edge; stimulus changes 1 time unit after the rising edge.
module tb_parity_frame_rx;

    localparam int CPB = 16;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    int   done_cnt0;
    int   done_cnt1;
    int   busy_cyc0;
    int   done_cyc0 [$];
    int   done_cyc1 [$];
    logic [3:0] done_dat1 [$];
    logic       done_perr1 [$];

    int   start_cyc;
    int   snap_done;
    int   snap_busy;

    parity_frame_rx_if #(.DATA_W(4)) if0 ();
    parity_frame_rx_if #(.DATA_W(4)) if1 ();

    parity_frame_rx #(.DATA_W(4), .CLKS_PER_BIT(CPB), .ODD(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    parity_frame_rx #(.DATA_W(4), .CLKS_PER_BIT(CPB), .ODD(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes and busy away from the active edge.
    always @(negedge clk) begin
        if (if0.frame_done === 1'b1) begin
            done_cnt0 = done_cnt0 + 1;
            done_cyc0.push_back(cyc);
        end
        if (if1.frame_done === 1'b1) begin
            done_cnt1 = done_cnt1 + 1;
            done_cyc1.push_back(cyc);
            done_dat1.push_back(if1.data_out);
            done_perr1.push_back(if1.parity_err);
        end
        if (if0.busy === 1'b1) busy_cyc0 = busy_cyc0 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic b);
        if (which == 0) if0.rx = b;
        else            if1.rx = b;
    endtask

    // Start bit, four data bits LSB-first, parity, stop; each bit lasts CPB cycles.
    task automatic send_frame(input int which, input logic [3:0] d, input logic p, input logic s);
        logic [6:0] bits;
        bits      = {s, p, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 7; i++) begin
            set_rx(which, bits[i]);
            step(CPB);
        end
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        done_cnt0 = 0;
        done_cnt1 = 0;
        busy_cyc0 = 0;
        rst       = 1'b1;
        if0.rx    = 1'b1;
        if1.rx    = 1'b1;
        step(3);

        // Reset state.
        check_eq("rst_data_out",   32'(if0.data_out),   32'h0);
        check_eq("rst_parity_out", 32'(if0.parity_out), 32'h0);
        check_eq("rst_frame_done", 32'(if0.frame_done), 32'h0);
        check_eq("rst_parity_err", 32'(if0.parity_err), 32'h0);
        check_eq("rst_frame_err",  32'(if0.frame_err),  32'h0);
        check_eq("rst_busy",       32'(if0.busy),       32'h0);
        check_eq("rst_busy_odd",   32'(if1.busy),       32'h0);
        rst = 1'b0;
        step(5);

        // 1: good frame; rx low to frame_done = 2 sync cycles + 105.
        send_frame(0, 4'b1011, 1'b1, 1'b1);
        step(10);
        check_eq("t1_done_cnt",    32'(done_cnt0), 32'd1);
        check_eq("t1_latency",     32'(done_cyc0[0] - start_cyc), 32'd107);
        check_eq("t1_data_out",    32'(if0.data_out),   32'hB);
        check_eq("t1_parity_out",  32'(if0.parity_out), 32'h1);
        check_eq("t1_parity_err",  32'(if0.parity_err), 32'h0);
        check_eq("t1_frame_err",   32'(if0.frame_err),  32'h0);
        check_eq("t1_busy",        32'(if0.busy),       32'h0);

        // 2: parity error, then a good frame clears it.
        send_frame(0, 4'b1011, 1'b0, 1'b1);
        step(10);
        check_eq("t2_done_cnt",    32'(done_cnt0), 32'd2);
        check_eq("t2_parity_err",  32'(if0.parity_err), 32'h1);
        check_eq("t2_frame_err",   32'(if0.frame_err),  32'h0);
        check_eq("t2_data_out",    32'(if0.data_out),   32'hB);
        check_eq("t2_parity_out",  32'(if0.parity_out), 32'h0);
        send_frame(0, 4'b1111, 1'b0, 1'b1);
        step(10);
        check_eq("t2b_done_cnt",   32'(done_cnt0), 32'd3);
        check_eq("t2b_parity_err", 32'(if0.parity_err), 32'h0);
        check_eq("t2b_data_out",   32'(if0.data_out),   32'hF);

        // 3: 4-cycle glitch; busy only for the CPB/2 cycles spent in START.
        snap_done = done_cnt0;
        snap_busy = busy_cyc0;
        if0.rx = 1'b0;
        step(4);
        if0.rx = 1'b1;
        step(30);
        check_eq("t3_busy_cycles", 32'(busy_cyc0 - snap_busy), 32'd8);
        check_eq("t3_busy_end",    32'(if0.busy),       32'h0);
        check_eq("t3_no_done",     32'(done_cnt0),      32'(snap_done));
        check_eq("t3_data_held",   32'(if0.data_out),   32'hF);
        check_eq("t3_perr_held",   32'(if0.parity_err), 32'h0);

        // 4: framing error, then line stuck low for 100 cycles.
        send_frame(0, 4'b0101, 1'b0, 1'b0);
        step(100);
        check_eq("t4_done_cnt",    32'(done_cnt0), 32'(snap_done + 1));
        check_eq("t4_frame_err",   32'(if0.frame_err),  32'h1);
        check_eq("t4_parity_err",  32'(if0.parity_err), 32'h0);
        check_eq("t4_data_out",    32'(if0.data_out),   32'h5);
        check_eq("t4_busy_stuck",  32'(if0.busy),       32'h1);
        if0.rx = 1'b1;
        step(5);
        check_eq("t4_busy_release", 32'(if0.busy),      32'h0);
        check_eq("t4_done_after",  32'(done_cnt0), 32'(snap_done + 1));
        step(5);
        send_frame(0, 4'b1001, 1'b0, 1'b1);
        step(10);
        check_eq("t4b_done_cnt",   32'(done_cnt0), 32'(snap_done + 2));
        check_eq("t4b_frame_err",  32'(if0.frame_err),  32'h0);
        check_eq("t4b_data_out",   32'(if0.data_out),   32'h9);

        // 5: reset asserted mid data bit 2 (bits so far: start 0, d0 1, d1 1, d2 0).
        snap_done = done_cnt0;
        if0.rx = 1'b0; step(CPB);
        if0.rx = 1'b1; step(CPB);
        if0.rx = 1'b1; step(CPB);
        if0.rx = 1'b0; step(CPB / 2);
        check_eq("t5_busy_before", 32'(if0.busy), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_data",    32'(if0.data_out),   32'h0);
        check_eq("t5_rst_busy",    32'(if0.busy),       32'h0);
        check_eq("t5_rst_done",    32'(if0.frame_done), 32'h0);
        check_eq("t5_rst_perr",    32'(if0.parity_err), 32'h0);
        check_eq("t5_rst_ferr",    32'(if0.frame_err),  32'h0);
        check_eq("t5_rst_pout",    32'(if0.parity_out), 32'h0);
        if0.rx = 1'b1;
        step(4);
        rst = 1'b0;
        step(20);
        check_eq("t5_no_done",     32'(done_cnt0), 32'(snap_done));
        send_frame(0, 4'b0011, 1'b0, 1'b1);
        step(10);
        check_eq("t5b_done_cnt",   32'(done_cnt0), 32'(snap_done + 1));
        check_eq("t5b_data_out",   32'(if0.data_out),   32'h3);
        check_eq("t5b_parity_err", 32'(if0.parity_err), 32'h0);
        check_eq("t5b_frame_err",  32'(if0.frame_err),  32'h0);

        // 6: odd parity, two frames with no idle gap between stop and next start.
        send_frame(1, 4'b0000, 1'b1, 1'b1);
        send_frame(1, 4'b1000, 1'b0, 1'b1);
        step(10);
        check_eq("t6_done_cnt",    32'(done_cnt1), 32'd2);
        if (done_cnt1 == 2) begin
            check_eq("t6_data0",   32'(done_dat1[0]),  32'h0);
            check_eq("t6_perr0",   32'(done_perr1[0]), 32'h0);
            check_eq("t6_data1",   32'(done_dat1[1]),  32'h8);
            check_eq("t6_perr1",   32'(done_perr1[1]), 32'h0);
            check_eq("t6_spacing", 32'(done_cyc1[1] - done_cyc1[0]), 32'd112);
        end
        check_eq("t6_parity_out",  32'(if1.parity_out), 32'h0);
        check_eq("t6_busy",        32'(if1.busy),       32'h0);
        check_eq("t6_dut0_quiet",  32'(done_cnt0), 32'(snap_done + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
